// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_W;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } arb_state_e;

  // One candidate write to the register file.
  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// Per-register pending flags for registers reserved by the long-latency unit.
module rf_scoreboard
  import rf_write_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_addr_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_addr_i,
  input  logic [REG_W-1:0] rs_addr_i,
  input  logic [REG_W-1:0] rt_addr_i,
  output logic             rs_busy_o,
  output logic             rt_busy_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Clear first so a same-cycle set to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_addr_i] = 1'b0;
    if (set_i && (set_addr_i != REG_ZERO)) pending_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign rs_busy_o = pending_q[rs_addr_i];
  assign rt_busy_o = pending_q[rt_addr_i];

endmodule

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by W-stage writeback and the long-latency unit.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we_i,
  input  logic [REG_W-1:0]  wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] wb_pc_i,
  input  logic              lu_issue_i,
  input  logic [REG_W-1:0]  lu_issue_addr_i,
  input  logic              lu_valid_i,
  input  logic [REG_W-1:0]  lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  input  logic [DATA_W-1:0] lu_pc_i,
  output logic              lu_ready_o,
  input  logic [REG_W-1:0]  rs_addr_i,
  input  logic [REG_W-1:0]  rt_addr_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic              stall_req_o,
  output logic              rf_we_o,
  output logic [REG_W-1:0]  rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [DATA_W-1:0] rf_wpc_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_ready, grant_wb, grant_lu, stall_req, lu_done;
  wr_req_t          wb_req, lu_req, sel_req;

  assign wb_req = '{addr: wb_addr_i, data: wb_data_i, pc: wb_pc_i};
  assign lu_req = '{addr: lu_addr_i, data: lu_data_i, pc: lu_pc_i};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lu_ready  = 1'b0;
    grant_wb  = 1'b0;
    grant_lu  = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_we_i) begin
          grant_wb = 1'b1;
        end else begin
          lu_ready = 1'b1;
          grant_lu = lu_valid_i;
        end
        if (lu_valid_i && !lu_ready) begin
          if (cnt_q == CNT_LAST) state_d = STALL;
          else                   cnt_d   = cnt_q + 1'b1;
        end else if (lu_valid_i && lu_ready) begin
          cnt_d = '0;
        end
      end
      STALL: begin
        // Whole pipeline frozen for one cycle; the port belongs to the LU.
        stall_req = 1'b1;
        lu_ready  = 1'b1;
        grant_lu  = 1'b1;
        state_d   = IDLE;
        cnt_d     = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_req = grant_lu ? lu_req : wb_req;
  assign lu_done = lu_valid_i & lu_ready;

  assign lu_ready_o  = lu_ready;
  assign stall_req_o = stall_req;
  assign rf_we_o     = (grant_wb | grant_lu) & (sel_req.addr != REG_ZERO);
  assign rf_waddr_o  = sel_req.addr;
  assign rf_wdata_o  = sel_req.data;
  assign rf_wpc_o    = sel_req.pc;

  rf_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_i      (lu_issue_i),
    .set_addr_i (lu_issue_addr_i),
    .clr_i      (lu_done),
    .clr_addr_i (lu_addr_i),
    .rs_addr_i  (rs_addr_i),
    .rt_addr_i  (rt_addr_i),
    .rs_busy_o  (rs_busy_o),
    .rt_busy_o  (rt_busy_o)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: constant vectors, corner sequences and a random run against a reference model.
module tb_rf_write_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we, lu_issue, lu_valid;
  logic [4:0]  wb_addr, lu_issue_addr, lu_addr, rs_addr, rt_addr;
  logic [31:0] wb_data, wb_pc, lu_data, lu_pc;
  logic        lu_ready, rs_busy, rt_busy, stall_req, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rf_wpc;

  always #5 clk = ~clk;

  rf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_pc_i(wb_pc),
    .lu_issue_i(lu_issue), .lu_issue_addr_i(lu_issue_addr),
    .lu_valid_i(lu_valid), .lu_addr_i(lu_addr), .lu_data_i(lu_data), .lu_pc_i(lu_pc),
    .lu_ready_o(lu_ready), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_busy_o(rs_busy), .rt_busy_o(rt_busy), .stall_req_o(stall_req),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_wpc_o(rf_wpc)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: reserved-register set, run of consecutive blocked cycles, freeze flag.
  logic [31:0] m_pend;
  int          m_run;
  bit          m_stall;
  bit          m_comp;

  // Last sampled DUT outputs, for sequence-specific checks.
  logic        s_ready, s_stall, s_we, s_rs, s_rt;
  logic [4:0]  s_waddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_in();
    wb_we = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
    lu_issue = 0; lu_issue_addr = 0; lu_valid = 0; lu_addr = 0; lu_data = 0; lu_pc = 0;
    rs_addr = 0; rt_addr = 0;
  endtask

  // One clock: inputs already driven at posedge+1; check at posedge+3, advance, update model.
  task automatic cyc();
    logic        e_ready, g_lu, g_wb, e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_wpc;
    #2;
    e_ready = m_stall || !wb_we;
    g_lu    = m_stall || (!wb_we && lu_valid);
    g_wb    = !m_stall && wb_we;
    e_waddr = g_lu ? lu_addr : wb_addr;
    e_wdata = g_lu ? lu_data : wb_data;
    e_wpc   = g_lu ? lu_pc   : wb_pc;
    e_we    = (g_lu || g_wb) && (e_waddr != 0);
    s_ready = lu_ready; s_stall = stall_req; s_we = rf_we; s_waddr = rf_waddr;
    s_rs = rs_busy; s_rt = rt_busy;
    check("lu_ready",  {31'd0, lu_ready},  {31'd0, e_ready});
    check("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
    check("rf_we",     {31'd0, rf_we},     {31'd0, e_we});
    check("rf_waddr",  {27'd0, rf_waddr},  {27'd0, e_waddr});
    check("rf_wdata",  rf_wdata, e_wdata);
    check("rf_wpc",    rf_wpc,   e_wpc);
    check("rs_busy",   {31'd0, rs_busy},   {31'd0, m_pend[rs_addr]});
    check("rt_busy",   {31'd0, rt_busy},   {31'd0, m_pend[rt_addr]});
    m_comp = lu_valid && e_ready;
    // Contract: only one LU op in flight (a reservation retiring this cycle is allowed).
    assert (reset || !lu_issue ||
            ((m_pend & ~(m_comp ? (32'd1 << lu_addr) : 32'd0)) == 32'd0))
      else $error("lu_issue while another reservation is outstanding");
    @(posedge clk);
    if (reset) begin
      m_pend = 0; m_run = 0; m_stall = 0;
    end else begin
      if (m_comp) m_pend[lu_addr] = 1'b0;
      if (lu_issue && lu_issue_addr != 0) m_pend[lu_issue_addr] = 1'b1;
      if (m_stall || m_comp) m_run = 0;
      else if (lu_valid)     m_run++;
      m_stall = !m_stall && (m_run == MAX_WAIT);
      if (m_stall) m_run = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    zero_in();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[6];
  int   ph, dly;
  logic [4:0] res;

  initial begin
    m_pend = 0; m_run = 0; m_stall = 0; m_comp = 0;
    zero_in();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    m_pend = 0; m_run = 0; m_stall = 0;
    reset = 0;

    // Reset state
    rs_addr = 5'd9; rt_addr = 5'd17;
    cyc();
    check("reset stall", {31'd0, s_stall}, 32'd0);
    check("reset rs",    {31'd0, s_rs},    32'd0);
    check("reset rt",    {31'd0, s_rt},    32'd0);

    // Single-cycle grant vectors from a clean IDLE state
    vecs[0] = '{1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 5'd5,  32'h1234};
    vecs[1] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd8,  32'hABCD, 1'b1, 1'b1, 5'd8,  32'hABCD};
    vecs[2] = '{1'b1, 5'd0,  32'h77,   1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 5'd0,  32'h77};
    vecs[3] = '{1'b0, 5'd3,  32'h1,    1'b1, 5'd0,  32'h99,   1'b1, 1'b0, 5'd0,  32'h99};
    vecs[4] = '{1'b0, 5'd7,  32'h55,   1'b0, 5'd2,  32'h66,   1'b1, 1'b0, 5'd7,  32'h55};
    vecs[5] = '{1'b1, 5'd12, 32'hC0DE, 1'b1, 5'd13, 32'hBEEF, 1'b0, 1'b1, 5'd12, 32'hC0DE};
    for (int i = 0; i < 6; i++) begin
      zero_in();
      wb_we = vecs[i].wb_we; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      lu_valid = vecs[i].lu_valid; lu_addr = vecs[i].lu_addr; lu_data = vecs[i].lu_data;
      cyc();
      check($sformatf("vec%0d ready", i), {31'd0, s_ready}, {31'd0, vecs[i].e_ready});
      check($sformatf("vec%0d we", i),    {31'd0, s_we},    {31'd0, vecs[i].e_we});
      check($sformatf("vec%0d waddr", i), {27'd0, s_waddr}, {27'd0, vecs[i].e_waddr});
      do_reset();
    end

    // LU write to r8 with scoreboard visibility
    zero_in(); lu_issue = 1; lu_issue_addr = 5'd8; rs_addr = 5'd8;
    cyc();
    check("r8 busy at issue", {31'd0, s_rs}, 32'd0);
    lu_issue = 0; cyc();
    check("r8 busy waiting", {31'd0, s_rs}, 32'd1);
    lu_valid = 1; lu_addr = 5'd8; lu_data = 32'hABCD;
    cyc();
    check("r8 busy at completion", {31'd0, s_rs}, 32'd1);
    check("r8 written", {31'd0, s_we}, 32'd1);
    lu_valid = 0; cyc();
    check("r8 free after", {31'd0, s_rs}, 32'd0);

    // Issue to r0 reserves nothing
    zero_in(); lu_issue = 1; cyc();
    lu_issue = 0; rs_addr = 0; rt_addr = 0; cyc();
    check("r0 never pending", {31'd0, s_rs}, 32'd0);

    // Same-cycle set and clear of r3
    zero_in(); lu_issue = 1; lu_issue_addr = 5'd3; cyc();
    lu_valid = 1; lu_addr = 5'd3; lu_data = 32'h3; cyc();
    lu_issue = 0; lu_valid = 0; rt_addr = 5'd3; cyc();
    check("r3 set wins", {31'd0, s_rt}, 32'd1);
    lu_valid = 1; cyc();
    lu_valid = 0; cyc();
    check("r3 cleared", {31'd0, s_rt}, 32'd0);

    // Starvation with WB every cycle
    do_reset();
    for (int c = 0; c < 6; c++) begin
      wb_we = 1; wb_addr = 5'd5; wb_data = 32'h1234;
      lu_valid = (c < 5); lu_addr = 5'd9; lu_data = 32'hABCD;
      cyc();
      if (c < 4) begin
        check($sformatf("starve c%0d ready", c), {31'd0, s_ready}, 32'd0);
        check($sformatf("starve c%0d stall", c), {31'd0, s_stall}, 32'd0);
      end else if (c == 4) begin
        check("starve c4 stall", {31'd0, s_stall}, 32'd1);
        check("starve c4 ready", {31'd0, s_ready}, 32'd1);
        check("starve c4 waddr", {27'd0, s_waddr}, 32'd9);
      end else begin
        check("starve c5 stall", {31'd0, s_stall}, 32'd0);
        check("starve c5 waddr", {27'd0, s_waddr}, 32'd5);
      end
    end

    // Reset during STALL while r9 is reserved
    do_reset();
    lu_issue = 1; lu_issue_addr = 5'd9; cyc();
    lu_issue = 0;
    for (int c = 0; c < 5; c++) begin
      wb_we = 1; wb_addr = 5'd4; lu_valid = 1; lu_addr = 5'd9; rs_addr = 5'd9;
      reset = (c == 4);
      cyc();
      if (c == 4) check("rst in stall", {31'd0, s_stall}, 32'd1);
    end
    reset = 0; lu_valid = 0; cyc();
    check("post-rst stall", {31'd0, s_stall}, 32'd0);
    check("post-rst r9",    {31'd0, s_rs},    32'd0);
    for (int c = 0; c < 5; c++) begin
      lu_valid = 1; cyc();
      check($sformatf("restart c%0d stall", c), {31'd0, s_stall}, {31'd0, c == 4});
    end
    lu_valid = 0; cyc();

    // Random traffic through a well-behaved LU agent
    do_reset();
    ph = 0; dly = 0; res = 0;
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      wb_we    = ($urandom_range(0, 3) != 0);
      wb_addr  = 5'($urandom); wb_data = $urandom; wb_pc = $urandom;
      rs_addr  = (ph != 0 && $urandom_range(0, 1) == 0) ? res : 5'($urandom);
      rt_addr  = 5'($urandom);
      lu_issue = 0;
      if (ph == 0 && $urandom_range(0, 2) == 0) begin
        lu_issue = 1; lu_issue_addr = 5'($urandom);
      end
      lu_valid = (ph == 2);
      cyc();
      if (reset) ph = 0;
      else if (ph == 2 && m_comp) ph = 0;
      else if (lu_issue) begin
        ph = 1; dly = $urandom_range(0, 3); res = lu_issue_addr;
      end else if (ph == 1) begin
        if (dly == 0) begin
          ph = 2; lu_addr = res; lu_data = $urandom; lu_pc = $urandom;
        end else dly--;
      end
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the 32x32 general register file.
- Shares that port between two writers:
  - the pipeline W-stage writeback, which has priority;
  - a long-latency unit (LU: multiply/divide result, delayed load), which uses a valid/ready handshake.
- Keeps a per-register pending scoreboard, so hazard logic can stall readers of registers the LU has reserved.
- Bounds LU starvation by requesting a one-cycle pipeline freeze.

Parameters:
- MAX_WAIT, 4, consecutive blocked LU cycles before a freeze is forced (legal range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- wb_we  in  1  W-stage write request
- wb_addr  in  5  W-stage destination register
- wb_data  in  32  W-stage write data
- wb_pc  in  32  PC of the W-stage instruction (trace)
- lu_issue  in  1  LU accepts a new op; reserves a destination register
- lu_issue_addr  in  5  reserved destination register
- lu_valid  in  1  LU result available
- lu_addr  in  5  LU result destination register
- lu_data  in  32  LU result data
- lu_pc  in  32  PC of the LU instruction
- lu_ready  out  1  LU result accepted this cycle
- rs_addr  in  5  D-stage source register 1
- rt_addr  in  5  D-stage source register 2
- rs_busy  out  1  rs register pending from LU
- rt_busy  out  1  rt register pending from LU
- stall_req  out  1  freeze every pipeline stage, W included, this cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- rf_wpc  out  32  PC passed to the register file trace output

Behaviour:
- Clocking: clock clk; reset reset, synchronous, active-high.
- Reset clears state to IDLE, the starvation counter to 0, and pending[31:0] to 0.
  - After reset: stall_req=0, rs_busy=rt_busy=0.
  - rf_we follows the inputs combinationally, with state at its reset values.
- Reset mid-operation discards every reservation and any LU handshake in progress; the LU is reset in the same cycle.
- Write outputs are combinational (0-cycle latency); the register file commits at the next posedge.
- State machine: IDLE and STALL.
  - IDLE, grant:
    - If wb_we=1, WB is granted and lu_ready=0.
    - Otherwise lu_ready=1; if lu_valid=1, LU is granted.
  - STALL:
    - stall_req=1 and lu_ready=1; LU is granted unconditionally.
    - The pipeline holds all stages and re-presents the same wb request next cycle.
    - The next state is always IDLE, with the counter cleared.
- Starvation counter:
  - In IDLE with lu_valid & ~lu_ready, the counter increments.
  - When it reaches MAX_WAIT-1 while still blocked, the next state is STALL.
  - Any LU handshake (lu_valid & lu_ready) clears the counter.
- Handshake rules:
  - lu_valid, once asserted, holds with lu_addr/lu_data/lu_pc stable until lu_ready=1.
  - Completion equals lu_valid & lu_ready.
- Write outputs:
  - rf_waddr/rf_wdata/rf_wpc come from the granted source; they are WB values when nothing is granted.
  - rf_we is set when a source is granted and its address != 0.
  - Writes to register 0 are suppressed; the LU handshake still completes.
- Scoreboard, per-register flag set/clear:
  - lu_issue sets pending[lu_issue_addr], except when the address is 0.
  - LU completion clears pending[lu_addr].
  - If issue and completion hit the same address in one cycle, set wins.
- The LU has at most one op in flight. lu_issue while any pending bit is set is a contract violation, flagged by a bench assertion.
- rs_busy = pending[rs_addr] and rt_busy = pending[rt_addr], combinational from the registered flags.
  - In the completion cycle busy stays 1; it drops the following cycle, once the register file holds the value.

Decomposition:
- Shared package holds:
  - IDLE/STALL state encodings;
  - the REG_ZERO constant (5'd0);
  - register-index width 5 and data width 32.
- Sub-module rf_scoreboard: the 32-bit pending vector with set/clear/read logic and two combinational read ports.
- Grant logic, state machine and counter stay in the top module.

Test Plan:
- Only WB writes, wb_we=1, wb_addr=5, wb_data=32'h1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=32'h1234; lu_ready=0.
- LU writes with no WB: lu_issue_addr=8, then lu_valid with lu_addr=8, lu_data=32'hABCD -> lu_ready=1 and rf_we=1 to reg 8. rs_addr=8 gives rs_busy=1 from the cycle after issue through the completion cycle, then 0.
- Starvation, MAX_WAIT=4: wb_we=1 every cycle, lu_valid=1 from cycle 0 -> lu_ready=0 for cycles 0-3. In cycle 4, stall_req=1, lu_ready=1 and rf_waddr=lu_addr. In cycle 5, stall_req=0 and WB is granted.
- Register 0: wb_addr=0 -> rf_we=0. LU completion to lu_addr=0 -> handshake completes, rf_we=0. lu_issue_addr=0 -> pending stays 0.
- Same-cycle set/clear: issue with addr 3 and completion with addr 3 in one cycle -> pending[3]=1 afterwards, so rt_addr=3 gives rt_busy=1.
- Reset while in STALL with pending[9]=1 -> next cycle stall_req=0, rs_busy=0 for rs_addr=9, counter restarts from 0.
